cpu6_ifu_prefetch: RTL and testbench

//  Instruction prefetch unit between instruction memory and cpu6_core fetch stage.

---
 rtl/cpu6_ifu_prefetch_pkg.sv | 11 +
 rtl/cpu6_fifo_sync.sv | 54 +++++
 rtl/cpu6_ifu_prefetch.sv | 110 +++++++++++
 tb/tb_cpu6_ifu_prefetch.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu6_ifu_prefetch_pkg.sv
// Shared constants and FSM state type for the cpu6 instruction prefetch unit.
package cpu6_ifu_prefetch_pkg;
  localparam int CPU6_XLEN = 32;
  localparam logic [CPU6_XLEN-1:0] NOP = 32'h00000013;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;
endpackage

// File: rtl/cpu6_fifo_sync.sv
// Small synchronous FIFO with a combinational head and a synchronous clear.
module cpu6_fifo_sync #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clear,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;

  // Pointers wrap explicitly so non-power-of-two depths work too.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
endmodule

// File: rtl/cpu6_ifu_prefetch.sv
// Instruction prefetch unit: credit-limited sequential fetch over req/gnt/rvalid,
// buffered {pc, instr} delivery to the core, and drop-counting on redirect.
module cpu6_ifu_prefetch
  import cpu6_ifu_prefetch_pkg::*;
#(
  parameter int                    DEPTH    = 2,
  parameter logic [CPU6_XLEN-1:0]  RESET_PC = 32'h00000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  redirect,
  input  logic [CPU6_XLEN-1:0]  redirect_pc,
  input  logic                  stallF,
  output logic                  instr_valid,
  output logic [CPU6_XLEN-1:0]  instr,
  output logic [CPU6_XLEN-1:0]  instr_pc,
  output logic                  imem_req,
  output logic [CPU6_XLEN-1:0]  imem_addr,
  input  logic                  imem_gnt,
  input  logic                  imem_rvalid,
  input  logic [CPU6_XLEN-1:0]  imem_rdata,
  output state_t                fsm_state
);
  localparam int XL = CPU6_XLEN;
  localparam int CW = $clog2(DEPTH + 1);

  // Handshake: a fetch is accepted on any cycle with imem_req & imem_gnt; responses
  // come back in request order one per imem_rvalid; the core consumes the head on
  // instr_valid & ~stallF.

  state_t         state, state_next;
  logic [XL-1:0]  fetch_pc;
  logic [CW-1:0]  outstanding, outstanding_next;
  logic [CW-1:0]  drop_cnt, drop_next;
  logic [CW-1:0]  count, pcq_count;
  logic [CW:0]    credit_used;
  logic           accept, keep, pop, buf_empty, pcq_empty;
  logic [XL-1:0]  pcq_head, head_pc, head_instr;

  assign credit_used = {1'b0, count} + {1'b0, outstanding};
  assign imem_req    = (state == ST_RUN) && !redirect && (credit_used < (CW+1)'(DEPTH));
  assign imem_addr   = fetch_pc;
  assign accept      = imem_req & imem_gnt;
  // A response is kept only if it belongs to the live stream.
  assign keep        = imem_rvalid & ~redirect & (drop_cnt == '0);
  assign instr_valid = ~buf_empty;
  assign pop         = instr_valid & ~stallF & ~redirect;
  assign instr       = instr_valid ? head_instr : NOP;
  assign instr_pc    = head_pc;
  assign fsm_state   = state;

  always_comb begin
    outstanding_next = outstanding + CW'(accept) - CW'(imem_rvalid);
    drop_next        = drop_cnt;
    state_next       = state;
    if (redirect)
      drop_next = outstanding_next;
    else if (imem_rvalid && drop_cnt != '0)
      drop_next = drop_cnt - CW'(1);
    case (state)
      ST_BOOT: state_next = ST_RUN;
      default: state_next = (drop_next != '0) ? ST_FLUSH : ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_BOOT;
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      state       <= state_next;
      outstanding <= outstanding_next;
      drop_cnt    <= drop_next;
      if (redirect)    fetch_pc <= redirect_pc & ~XL'(3);
      else if (accept) fetch_pc <= fetch_pc + XL'(4);
    end
  end

  // In-flight PCs: one entry per accepted request, retired by its response even when dropped.
  cpu6_fifo_sync #(.WIDTH(XL), .DEPTH(DEPTH)) u_pcq (
    .clk       (clk),
    .reset     (reset),
    .clear     (1'b0),
    .push      (accept),
    .push_data (fetch_pc),
    .pop       (imem_rvalid),
    .head      (pcq_head),
    .count     (pcq_count),
    .empty     (pcq_empty)
  );

  cpu6_fifo_sync #(.WIDTH(2*XL), .DEPTH(DEPTH)) u_buf (
    .clk       (clk),
    .reset     (reset),
    .clear     (redirect),
    .push      (keep),
    .push_data ({pcq_head, imem_rdata}),
    .pop       (pop),
    .head      ({head_pc, head_instr}),
    .count     (count),
    .empty     (buf_empty)
  );

  a_outstanding_bound: assert property (@(posedge clk) disable iff (reset)
    outstanding <= CW'(DEPTH));
  a_pcq_tracks: assert property (@(posedge clk) disable iff (reset)
    (pcq_count == outstanding) && !(imem_rvalid && pcq_empty));
endmodule

// File: tb/tb_cpu6_ifu_prefetch.sv
// Bench for cpu6_ifu_prefetch: in-order memory model, queue-based reference model
// compared every cycle, directed scenarios with literal pins, then random traffic.
module tb_cpu6_ifu_prefetch;
  import cpu6_ifu_prefetch_pkg::*;

  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h00000000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        stallF = 1'b0;
  logic        instr_valid;
  logic [31:0] instr, instr_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  state_t      fsm_state;

  int total = 0;
  int bad = 0;
  bit check_en = 1'b0;

  always #5 clk = ~clk;

  cpu6_ifu_prefetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .reset       (reset),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .stallF      (stallF),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .fsm_state   (fsm_state)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h00001F13;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  // Memory: remembers accepted addresses and answers them in order.
  logic [31:0] mem_q[$];
  logic        bus_acc = 1'b0;
  logic [31:0] bus_addr = '0;
  logic [31:0] mem_dummy;

  always @(negedge clk) begin
    bus_acc  = imem_req & imem_gnt;
    bus_addr = imem_addr;
  end

  always @(posedge clk or posedge reset) begin
    if (reset) mem_q.delete();
    else begin
      if (imem_rvalid && mem_q.size() > 0) mem_dummy = mem_q.pop_front();
      if (bus_acc) mem_q.push_back(bus_addr);
    end
  end

  // Reference model: buffered PCs (exp_q), in-flight PCs (fl_q) whose first
  // 'stale' entries belong to a discarded stream, and the next fetch address.
  logic [31:0] exp_q[$];
  logic [31:0] fl_q[$];
  int          stale = 0;
  bit          booted = 1'b0;
  logic [31:0] m_fetch = RESET_PC;
  logic [31:0] m_tmp;

  function automatic bit exp_req();
    return booted && !redirect && stale == 0 && (exp_q.size() + fl_q.size() < DEPTH);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      exp_q.delete();
      fl_q.delete();
      stale   = 0;
      booted  = 1'b0;
      m_fetch = RESET_PC;
    end else begin
      bit acc, do_pop;
      acc    = exp_req() && imem_gnt;
      do_pop = exp_q.size() > 0 && !stallF && !redirect;
      if (do_pop) m_tmp = exp_q.pop_front();
      if (imem_rvalid && fl_q.size() > 0) begin
        m_tmp = fl_q.pop_front();
        if (stale > 0) stale--;
        else if (!redirect) exp_q.push_back(m_tmp);
      end
      if (acc) begin
        fl_q.push_back(m_fetch);
        m_fetch = m_fetch + 32'd4;
      end
      if (redirect) begin
        exp_q.delete();
        stale   = fl_q.size();
        m_fetch = redirect_pc & 32'hFFFFFFFC;
      end
      booted = 1'b1;
    end
  end

  // Compare process: DUT outputs against the model on every live cycle.
  always @(negedge clk) begin
    if (check_en && !reset) begin
      chk("imem_req", 32'(imem_req), 32'(exp_req()));
      chk("imem_addr", imem_addr, m_fetch);
      chk("instr_valid", 32'(instr_valid), 32'(exp_q.size() > 0));
      if (exp_q.size() > 0) begin
        chk("instr_pc", instr_pc, exp_q[0]);
        chk("instr", instr, mem_word(exp_q[0]));
      end else begin
        chk("instr_nop", instr, NOP);
      end
      chk("fsm_state", 32'(fsm_state),
          32'(!booted ? ST_BOOT : (stale > 0 ? ST_FLUSH : ST_RUN)));
    end
  end

  task automatic drive(input logic s, input logic g, input logic r,
                       input logic [31:0] rpc, input int rv_pct);
    @(posedge clk);
    #1;
    stallF      = s;
    imem_gnt    = g;
    redirect    = r;
    redirect_pc = rpc;
    if (mem_q.size() > 0 && int'($urandom_range(99)) < rv_pct) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(mem_q[0]);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    @(negedge clk);
  endtask

  task automatic wait_valid(input string name, input logic [31:0] exp_pc);
    int n;
    n = 0;
    while (!instr_valid && n < 20) begin
      drive(1'b0, 1'b1, 1'b0, '0, 100);
      n++;
    end
    chk({name, "_valid"}, 32'(instr_valid), 32'd1);
    chk({name, "_pc"}, instr_pc, exp_pc);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    repeat (2) @(posedge clk);
    #1;
    reset    = 1'b0;
    check_en = 1'b1;
    @(negedge clk);
    chk("rst_state", 32'(fsm_state), 32'(ST_BOOT));
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, NOP);

    // 1: streaming with immediate grant and next-cycle response
    drive(1'b0, 1'b1, 1'b0, '0, 100);
    chk("t1_req", 32'(imem_req), 32'd1);
    chk("t1_addr0", imem_addr, 32'h0);
    drive(1'b0, 1'b1, 1'b0, '0, 100);
    chk("t1_addr1", imem_addr, 32'h4);
    drive(1'b0, 1'b1, 1'b0, '0, 100);
    chk("t1_pc0", instr_pc, 32'h0);
    chk("t1_instr0", instr, mem_word(32'h0));
    drive(1'b0, 1'b1, 1'b0, '0, 100);
    chk("t1_pc1", instr_pc, 32'h4);
    repeat (8) drive(1'b0, 1'b1, 1'b0, '0, 100);

    // 2: stall until the buffer holds two entries
    repeat (5) drive(1'b1, 1'b1, 1'b0, '0, 100);
    chk("t2_req_low", 32'(imem_req), 32'd0);
    chk("t2_valid", 32'(instr_valid), 32'd1);
    repeat (6) drive(1'b0, 1'b1, 1'b0, '0, 100);

    // 3: redirect with two requests outstanding
    repeat (4) drive(1'b0, 1'b0, 1'b0, '0, 100);
    repeat (3) drive(1'b1, 1'b1, 1'b0, '0, 0);
    drive(1'b1, 1'b1, 1'b1, 32'h100, 0);
    drive(1'b0, 1'b1, 1'b0, '0, 0);
    chk("t3_flush", 32'(fsm_state), 32'(ST_FLUSH));
    chk("t3_addr", imem_addr, 32'h100);
    chk("t3_req_low", 32'(imem_req), 32'd0);
    wait_valid("t3_first", 32'h100);
    repeat (4) drive(1'b0, 1'b1, 1'b0, '0, 100);

    // 4: redirect coinciding with grant and response
    repeat (3) drive(1'b0, 1'b1, 1'b0, '0, 100);
    drive(1'b0, 1'b1, 1'b1, 32'h300, 100);
    drive(1'b0, 1'b1, 1'b0, '0, 100);
    chk("t4_valid_fall", 32'(instr_valid), 32'd0);
    wait_valid("t4_first", 32'h300);

    // 5: alignment and address wrap
    drive(1'b0, 1'b1, 1'b1, 32'h203, 100);
    drive(1'b0, 1'b0, 1'b0, '0, 100);
    chk("t5_align", imem_addr, 32'h200);
    repeat (4) drive(1'b0, 1'b0, 1'b0, '0, 100);
    drive(1'b0, 1'b0, 1'b1, 32'hFFFFFFFF, 100);
    drive(1'b0, 1'b1, 1'b0, '0, 100);
    chk("t5_top", imem_addr, 32'hFFFFFFFC);
    drive(1'b0, 1'b1, 1'b0, '0, 100);
    chk("t5_wrap", imem_addr, 32'h0);
    repeat (4) drive(1'b0, 1'b1, 1'b0, '0, 100);

    // 6: reset mid-stream with a full buffer
    repeat (6) drive(1'b1, 1'b1, 1'b0, '0, 100);
    chk("t6_full", 32'(instr_valid), 32'd1);
    #1;
    reset       = 1'b1;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    stallF      = 1'b0;
    #1;
    chk("t6_valid", 32'(instr_valid), 32'd0);
    chk("t6_instr", instr, NOP);
    chk("t6_req", 32'(imem_req), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, '0, 100);
    chk("t6_refetch", imem_addr, RESET_PC);
    chk("t6_refetch_req", 32'(imem_req), 32'd1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      logic s, g, r;
      logic [31:0] rpc;
      s   = int'($urandom_range(99)) < 30;
      g   = int'($urandom_range(99)) < 70;
      r   = int'($urandom_range(99)) < 6;
      rpc = ($urandom_range(3) == 0) ? (32'hFFFFFFF0 | 32'($urandom_range(15))) : $urandom;
      drive(s, g, r, rpc, 60);
    end
    repeat (6) drive(1'b0, 1'b0, 1'b0, '0, 100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
